// File: rtl/afifo_wptr_full_if.sv
// Write-side bundle of the async FIFO pointer block: user write request,
// read-domain pointer in, and write status/pointer out.
interface afifo_wptr_full_if #(
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W:0]   rptr_gray_async;
   logic              wr_accept;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   wptr_gray;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   wr_fill;
   logic              overflow;

   modport master (
      output wr_en,
      output rptr_gray_async,
      input  wr_accept,
      input  wr_addr,
      input  wptr_gray,
      input  full,
      input  almost_full,
      input  wr_fill,
      input  overflow
   );

   modport slave (
      input  wr_en,
      input  rptr_gray_async,
      output wr_accept,
      output wr_addr,
      output wptr_gray,
      output full,
      output almost_full,
      output wr_fill,
      output overflow
   );
endinterface

// File: rtl/afifo_wptr_full.sv
// Write-domain pointer and full-flag manager of the async FIFO, with the
// Gray-to-binary converter it uses for the synchronized read pointer.
module afifo_wptr_full #(
   parameter int ADDR_W       = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 12
) (
   input logic              clk,
   input logic              rst_n,
   afifo_wptr_full_if.slave bus
);
   localparam int PW = ADDR_W + 1;
   localparam logic [ADDR_W:0] AFULL_VAL = PW'(AFULL_THRESH);

   logic [ADDR_W:0] sync_q [SYNC_STAGES];
   logic [ADDR_W:0] rq_sync;
   logic [ADDR_W:0] rbin_sync;
   logic [ADDR_W:0] wbin;
   logic [ADDR_W:0] wbin_next;
   logic [ADDR_W:0] wgray_next;
   logic [ADDR_W:0] fill_next;
   logic [ADDR_W:0] full_match;
   logic [ADDR_W:0] wptr_gray_q;
   logic [ADDR_W:0] wr_fill_q;
   logic            full_q;
   logic            almost_full_q;
   logic            overflow_q;
   logic            wr_accept_int;

   // Plain flop chain: the Gray source guarantees single-bit steps, so no
   // logic may sit between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.rptr_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign rq_sync = sync_q[SYNC_STAGES-1];

   gray2bin #(.WIDTH(PW)) u_gray2bin (
      .gray (rq_sync),
      .bin  (rbin_sync)
   );

   // Gated with rst_n so no RAM write can slip through while in reset.
   assign wr_accept_int = rst_n & bus.wr_en & ~full_q;
   assign wbin_next     = wbin + {{ADDR_W{1'b0}}, wr_accept_int};
   assign wgray_next    = wbin_next ^ (wbin_next >> 1);
   assign fill_next     = wbin_next - rbin_sync;
   assign full_match    = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};

   // Full compares against a stale read pointer, so it can only be late to
   // clear, never early.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin          <= '0;
         wptr_gray_q   <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         wr_fill_q     <= '0;
         overflow_q    <= 1'b0;
      end else begin
         wbin          <= wbin_next;
         wptr_gray_q   <= wgray_next;
         full_q        <= (wgray_next == full_match);
         almost_full_q <= (fill_next >= AFULL_VAL);
         wr_fill_q     <= fill_next;
         overflow_q    <= bus.wr_en & full_q;
      end
   end

   assign bus.wr_accept   = wr_accept_int;
   assign bus.wr_addr     = wbin[ADDR_W-1:0];
   assign bus.wptr_gray   = wptr_gray_q;
   assign bus.full        = full_q;
   assign bus.almost_full = almost_full_q;
   assign bus.wr_fill     = wr_fill_q;
   assign bus.overflow    = overflow_q;
endmodule

module gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);
   // Each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end
endmodule

// File: tb/tb_afifo_wptr_full.sv
// Scoreboard bench for afifo_wptr_full: two instances (2-stage/thresh 12 and
// 3-stage/thresh 16) share stimulus; a monitor pops expected records per cycle.
module tb_afifo_wptr_full;
   logic clk;
   logic rst_n;

   afifo_wptr_full_if #(.ADDR_W(4)) bus_a ();
   afifo_wptr_full_if #(.ADDR_W(4)) bus_b ();

   assign bus_b.wr_en           = bus_a.wr_en;
   assign bus_b.rptr_gray_async = bus_a.rptr_gray_async;

   afifo_wptr_full #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   afifo_wptr_full #(.ADDR_W(4), .SYNC_STAGES(3), .AFULL_THRESH(16)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         first;
      logic       acc;
      logic       acc2;
      logic [3:0] addr;
      logic [4:0] gray;
      logic       full;
      logic       afull;
      logic       ovf;
      logic [4:0] fill;
      logic       full2;
      logic       afull2;
      logic [4:0] fill2;
   } exp_t;

   exp_t sbQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   // Reference state per instance: index 0 = 2-stage, 1 = 3-stage.
   logic [4:0] mW [2];
   logic [4:0] mSync [2][3];
   logic       mFull [2];
   int         nStages [2] = '{2, 3};
   int         thresh [2] = '{12, 16};
   bit         firstFlag;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [4:0] toGray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [4:0] fromGray(input logic [4:0] g);
      logic [4:0] b;
      b[4] = g[4];
      for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic void resetModel();
      for (int d = 0; d < 2; d++) begin
         mW[d] = '0;
         mFull[d] = 1'b0;
         for (int s = 0; s < 3; s++) mSync[d][s] = '0;
      end
      firstFlag = 1'b1;
   endfunction

   // Advances the reference by one edge; full is derived from fill == DEPTH.
   function automatic exp_t modelStep(input logic we, input logic [4:0] rp);
      exp_t e;
      logic       acc [2];
      logic [4:0] fn [2];
      logic       ovf [2];
      for (int d = 0; d < 2; d++) begin
         acc[d] = we && !mFull[d];
         ovf[d] = we && mFull[d];
         mW[d]  = mW[d] + {4'd0, acc[d]};
         fn[d]  = mW[d] - fromGray(mSync[d][nStages[d]-1]);
         mFull[d] = (fn[d] == 5'd16);
         for (int s = nStages[d] - 1; s > 0; s--) mSync[d][s] = mSync[d][s-1];
         mSync[d][0] = rp;
      end
      e.name   = "step";
      e.first  = firstFlag;
      firstFlag = 1'b0;
      e.acc    = acc[0];
      e.acc2   = acc[1];
      e.addr   = mW[0][3:0];
      e.gray   = toGray(mW[0]);
      e.full   = mFull[0];
      e.afull  = (int'(fn[0]) >= thresh[0]);
      e.ovf    = ovf[0];
      e.fill   = fn[0];
      e.full2  = mFull[1];
      e.afull2 = (int'(fn[1]) >= thresh[1]);
      e.fill2  = fn[1];
      return e;
   endfunction

   task automatic applyStimulus(input logic we, input logic [4:0] rp, input exp_t e);
      @(posedge clk);
      #1;
      bus_a.wr_en = we;
      bus_a.rptr_gray_async = rp;
      sbQ.push_back(e);
   endtask

   task automatic drainQueue();
      for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(posedge clk);
      if (sbQ.size() > 0) checkOutput("drain_timeout", 32'(sbQ.size()), 0);
      @(posedge clk);
      #3;
   endtask

   // Monitor: wr_accept is sampled mid-cycle, registered outputs just after the edge.
   initial begin : monitor
      exp_t       r;
      logic [4:0] prevGray;
      bit         havePrev;
      havePrev = 1'b0;
      prevGray = '0;
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            r = sbQ.pop_front();
            if (r.first) havePrev = 1'b0;
            checkOutput({r.name, "_acc"},  32'(bus_a.wr_accept), 32'(r.acc));
            checkOutput({r.name, "_acc2"}, 32'(bus_b.wr_accept), 32'(r.acc2));
            @(posedge clk);
            #1;
            checkOutput({r.name, "_addr"},   32'(bus_a.wr_addr),     32'(r.addr));
            checkOutput({r.name, "_gray"},   32'(bus_a.wptr_gray),   32'(r.gray));
            checkOutput({r.name, "_full"},   32'(bus_a.full),        32'(r.full));
            checkOutput({r.name, "_afull"},  32'(bus_a.almost_full), 32'(r.afull));
            checkOutput({r.name, "_ovf"},    32'(bus_a.overflow),    32'(r.ovf));
            checkOutput({r.name, "_fill"},   32'(bus_a.wr_fill),     32'(r.fill));
            checkOutput({r.name, "_full2"},  32'(bus_b.full),        32'(r.full2));
            checkOutput({r.name, "_afull2"}, 32'(bus_b.almost_full), 32'(r.afull2));
            checkOutput({r.name, "_fill2"},  32'(bus_b.wr_fill),     32'(r.fill2));
            if (havePrev)
               checkOutput({r.name, "_onebit"}, 32'($countones(prevGray ^ bus_a.wptr_gray) <= 1), 1);
            prevGray = bus_a.wptr_gray;
            havePrev = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_acc"},   32'(bus_a.wr_accept),   0);
      checkOutput({tag, "_addr"},  32'(bus_a.wr_addr),     0);
      checkOutput({tag, "_gray"},  32'(bus_a.wptr_gray),   0);
      checkOutput({tag, "_full"},  32'(bus_a.full),        0);
      checkOutput({tag, "_afull"}, 32'(bus_a.almost_full), 0);
      checkOutput({tag, "_fill"},  32'(bus_a.wr_fill),     0);
      checkOutput({tag, "_ovf"},   32'(bus_a.overflow),    0);
      checkOutput({tag, "_full2"}, 32'(bus_b.full),        0);
      checkOutput({tag, "_fill2"}, 32'(bus_b.wr_fill),     0);
      checkOutput({tag, "_acc2"},  32'(bus_b.wr_accept),   0);
   endtask

   initial begin : stimulus
      exp_t       e;
      logic [4:0] rp;
      bit         wrapped;
      int         guard;

      rst_n = 1'b1;
      bus_a.wr_en = 1'b0;
      bus_a.rptr_gray_async = '0;
      resetModel();
      #2;
      rst_n = 1'b0;
      bus_a.wr_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkAllZero("reset");
      bus_a.wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to full with the read pointer parked at 0.
      for (int k = 1; k <= 17; k++) begin
         e = modelStep(1'b1, 5'd0);
         e.name = $sformatf("fill%0d", k);
         if (k == 12) begin
            e.afull = 1'b1; e.fill = 5'd12;
         end
         if (k == 16) begin
            e.full = 1'b1; e.fill = 5'd16; e.gray = 5'b11000;
            e.full2 = 1'b1; e.afull2 = 1'b1;
         end
         if (k == 17) begin
            e.acc = 1'b0; e.ovf = 1'b1; e.gray = 5'b11000;
         end
         applyStimulus(1'b1, 5'd0, e);
      end
      e = modelStep(1'b0, 5'd0);
      e.name = "ovf_single";
      e.ovf = 1'b0;
      applyStimulus(1'b0, 5'd0, e);

      // Read pointer jumps to 4: full clears 3 edges later (4 on the 3-stage copy).
      for (int i = 1; i <= 5; i++) begin
         e = modelStep(1'b0, 5'b00110);
         e.name = $sformatf("drain4_%0d", i);
         if (i <= 2) e.full = 1'b1;
         if (i == 3) begin
            e.full = 1'b0; e.fill = 5'd12; e.afull = 1'b1; e.full2 = 1'b1;
         end
         if (i == 4) begin
            e.full2 = 1'b0; e.fill2 = 5'd12; e.afull2 = 1'b0;
         end
         applyStimulus(1'b0, 5'b00110, e);
      end
      for (int i = 1; i <= 4; i++) begin
         e = modelStep(1'b0, 5'b00111);
         e.name = $sformatf("drain5_%0d", i);
         if (i == 3) begin
            e.fill = 5'd11; e.afull = 1'b0;
         end
         if (i == 4) e.fill2 = 5'd11;
         applyStimulus(1'b0, 5'b00111, e);
      end

      // Refill to full, then keep writing while the read pointer steps by one.
      for (int k = 1; k <= 5; k++) begin
         e = modelStep(1'b1, 5'b00111);
         e.name = $sformatf("refill%0d", k);
         if (k == 5) begin
            e.full = 1'b1; e.fill = 5'd16;
         end
         applyStimulus(1'b1, 5'b00111, e);
      end
      for (int i = 1; i <= 6; i++) begin
         e = modelStep(1'b1, 5'b00101);
         e.name = $sformatf("simul%0d", i);
         if (i <= 2) begin
            e.acc = 1'b0; e.full = 1'b1; e.ovf = 1'b1;
         end
         if (i == 3) begin
            e.acc = 1'b0; e.full = 1'b0; e.fill = 5'd15; e.ovf = 1'b1;
         end
         if (i == 4) begin
            e.acc = 1'b1; e.full = 1'b1; e.fill = 5'd16; e.ovf = 1'b0;
         end
         applyStimulus(1'b1, 5'b00101, e);
      end
      for (int i = 1; i <= 2; i++) begin
         e = modelStep(1'b0, 5'b00101);
         e.name = "simul_idle";
         applyStimulus(1'b0, 5'b00101, e);
      end

      // Stream writes with reads trailing by 4 until the write pointer wraps to 4.
      wrapped = 1'b0;
      guard = 0;
      do begin
         rp = toGray(mW[0] - 5'd4);
         e = modelStep(1'b1, rp);
         e.name = "wrap";
         if (mW[0] == 5'd31) begin
            e.name = "wrap_pre"; e.gray = 5'b10000;
         end
         if (mW[0] == 5'd0) begin
            e.name = "wrap_zero"; e.gray = 5'b00000; wrapped = 1'b1;
         end
         applyStimulus(1'b1, rp, e);
         guard++;
      end while (!(wrapped && mW[0] == 5'd4) && guard < 200);
      checkOutput("wrap_reached", 32'(wrapped && mW[0] == 5'd4), 1);

      for (int i = 1; i <= 5; i++) begin
         e = modelStep(1'b0, 5'b11110);
         e.name = $sformatf("wrapfull%0d", i);
         if (i == 5) begin
            e.full = 1'b1; e.fill = 5'd16; e.gray = 5'b00110; e.addr = 4'd4;
         end
         applyStimulus(1'b0, 5'b11110, e);
      end
      drainQueue();

      // Asynchronous reset between edges with a write request pending.
      bus_a.wr_en = 1'b1;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_rst");
      @(posedge clk);
      #1;
      checkAllZero("async_rst_hold");
      bus_a.wr_en = 1'b0;
      bus_a.rptr_gray_async = '0;
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_addr", 32'(bus_a.wr_addr), 0);
      for (int k = 1; k <= 3; k++) begin
         e = modelStep(1'b1, 5'd0);
         e.name = $sformatf("restart%0d", k);
         if (k == 1) begin
            e.acc = 1'b1; e.addr = 4'd1; e.fill = 5'd1; e.gray = 5'b00001;
         end
         applyStimulus(1'b1, 5'd0, e);
      end
      e = modelStep(1'b0, 5'd0);
      e.name = "restart_idle";
      applyStimulus(1'b0, 5'd0, e);
      drainQueue();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/afifo_wptr_full.md
Name: afifo_wptr_full

Overview:
Write-side pointer and full-flag manager of the async FIFO. It brings the read-domain Gray read pointer into the write clock domain through a synchronizer chain. It converts the synchronized pointer to binary with the existing gray2bin block (WIDTH = ADDR_W+1) and uses it to produce full, almost_full and fill level. It owns the write pointer, in binary for RAM addressing and in Gray for export to the read-domain synchronizer.

Parameters:
ADDR_W, 4, RAM address width; DEPTH = 2^ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, flop stages on the incoming read pointer (legal 2..4).
AFULL_THRESH, 12, almost_full asserts when fill >= this value (legal 1..DEPTH).

Ports:
clk  in  1  write-domain clock; all flops rising-edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write request from the write-side user.
rptr_gray_async  in  ADDR_W+1  Gray read pointer from the read domain, unsynchronized.
wr_accept  out  1  wr_en & ~full; RAM write strobe.
wr_addr  out  ADDR_W  RAM write address = wbin[ADDR_W-1:0].
wptr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
full  out  1  registered full flag.
almost_full  out  1  registered, fill >= AFULL_THRESH.
wr_fill  out  ADDR_W+1  registered occupancy as seen by the write side, 0..DEPTH.
overflow  out  1  one-cycle pulse: wr_en sampled while full.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without clk):
  - all sync stages, wbin, wptr_gray, full, almost_full, wr_fill and overflow go to 0.
  - wr_accept = 0 whenever rst_n is low.
  - On release, the first rising edge behaves as normal operation.
- Synchronizer: rptr_gray_async passes through SYNC_STAGES flops; the last stage is rq_sync. There is no logic between stages.
- gray2bin(rq_sync) -> rbin_sync (combinational).
- Next-state terms (combinational):
  - wbin_next = wbin + wr_accept, modulo 2^(ADDR_W+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - fill_next = (wbin_next - rbin_sync) modulo 2^(ADDR_W+1).
- Each clk edge registers:
  - wbin <= wbin_next.
  - wptr_gray <= wgray_next.
  - full <= (wgray_next == {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]}).
  - wr_fill <= fill_next.
  - almost_full <= (fill_next >= AFULL_THRESH).
  - overflow <= wr_en & full.
- Latency:
  - A write sets full and updates wr_fill on the same edge that increments wbin.
  - A read-pointer change at the input reaches rq_sync after SYNC_STAGES edges. full, wr_fill and almost_full reflect it on the next edge, SYNC_STAGES+1 edges after the change.
- Pessimism: full may stay high while space exists (stale rptr) but never deasserts early. The FIFO is never overwritten.
- Write while full: rejected. wbin and wptr_gray are held, wr_accept = 0, overflow pulses on the next edge. An overflow pulse on consecutive cycles is legal if wr_en stays high.
- Simultaneous wr_en and full deassert on the same edge: the write in that cycle uses the old full=1 and is rejected. It is accepted on a later cycle.
- Wrap-around: the pointers wrap 2^(ADDR_W+1)-1 -> 0. Gray changes exactly one bit per increment, including at the wrap. Fill arithmetic is modular and correct across the wrap.
- wptr_gray changes at most one bit per clk edge; the read-domain synchronizer relies on this.
- wr_fill never exceeds DEPTH given a legal read pointer. Behaviour for an illegal read pointer (read past write) is undefined.

Test Plan:
- Async reset: pulse rst_n low mid-stream between edges -> all outputs 0 immediately; after release, wbin restarts at 0 and wr_addr = 0.
- Fill to full: ADDR_W=4, rptr held 0, wr_en high.
  - After the 12th accept: almost_full=1, wr_fill=12.
  - After the 16th accept: full=1, wr_fill=16, wptr_gray=5'b11000.
  - 17th request: wr_accept=0, overflow=1 for one cycle, wptr_gray unchanged.
- Drain latency: from full, drive rptr_gray_async=5'b00110 (bin 4) -> full falls exactly 3 edges later, with wr_fill=12 and almost_full=1. Driving 5'b00111 (bin 5) gives wr_fill=11 and almost_full=0.
- Wrap-around: advance writes and reads past pointer 31.
  - wptr_gray steps 5'b10000 -> 5'b00000 at the wrap.
  - Single-bit change on every step (checker).
  - With wbin=4 and rptr=5'b11110 (bin 20): full=1, wr_fill=16.
- Simultaneous events: while full, hold wr_en high and advance the read pointer by 1 -> write rejected until full drops, then exactly one accept refills, and full reasserts.
- Parameter sweep: SYNC_STAGES=3 -> full deassert latency of 4 edges. AFULL_THRESH=16 -> almost_full coincides with full.
